// File: rtl/inst_mem_pkg.sv
// Shared defaults and state encoding for the loadable instruction store.
package inst_mem_pkg;

    localparam int IM_DATA_W = 16;
    localparam int IM_ADDR_W = 8;
    localparam int IM_DIR_W  = 32;
    localparam logic [15:0] IM_FILL_WORD = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/inst_mem_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module inst_mem_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/inst_mem_ctrl.sv
// Loadable instruction store: clear, host load, fetch with halt and range flags.
module inst_mem_ctrl
    import inst_mem_pkg::*;
#(
    parameter int                DATA_W       = IM_DATA_W,
    parameter int                ADDR_W       = IM_ADDR_W,
    parameter int                DIR_W        = IM_DIR_W,
    parameter logic [DATA_W-1:0] FILL_WORD    = IM_FILL_WORD,
    parameter bit                HALT_ON_LAST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              start,
    input  logic [DIR_W-1:0]  i_dir,
    input  logic              rd_en,
    output logic [DATA_W-1:0] o_dir,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0]  LAST_PTR = (ADDR_W+1)'(DEPTH-1);
    localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(DEPTH-1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_data;
    logic              fill_sel;
    logic              ld_fire, fetch, oor, hit_last;

    assign ld_ready = (state_q == ST_LOAD) && !ptr_q[ADDR_W];
    assign ld_fire  = ld_valid && ld_ready && !start;
    assign fetch    = (state_q == ST_RUN) && rd_en && !start;
    assign oor      = |i_dir[DIR_W-1:ADDR_W];
    assign hit_last = HALT_ON_LAST && (i_dir == LAST_DIR);
    assign o_busy   = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
    assign o_dir    = fill_sel ? FILL_WORD : rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we      = 1'b0;
        waddr   = ptr_q[ADDR_W-1:0];
        wdata   = FILL_WORD;
        if (start) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    we = 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        state_d = ST_LOAD;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ld_fire) begin
                        we    = 1'b1;
                        wdata = ld_data;
                        ptr_d = ptr_q + 1'b1;
                        // A full store ends the load even without ld_last
                        if (ld_last || ptr_q == LAST_PTR) state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fetch && hit_last) state_d = ST_DONE;
                end
                ST_DONE: ;
                default: state_d = ST_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid  <= 1'b0;
            fill_sel <= 1'b1;
            o_err    <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_valid <= fetch;
            if (fetch) fill_sel <= oor;
            if (start) begin
                o_err  <= 1'b0;
                o_done <= 1'b0;
            end else begin
                if (fetch && oor) o_err <= 1'b1;
                if (fetch && hit_last) o_done <= 1'b1;
            end
        end
    end

    inst_mem_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .re   (fetch),
        .raddr(i_dir[ADDR_W-1:0]),
        .rdata(rd_data)
    );

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Randomized self-checking bench for inst_mem_ctrl against an array model.
module tb_inst_mem_ctrl;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [15:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        start = 1'b0;
    logic [31:0] i_dir = '0;
    logic        rd_en = 1'b0;
    logic [15:0] o_dir;
    logic        o_valid;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int total = 0;
    int bad = 0;
    logic [15:0] model [DEPTH];

    always #5 clk = ~clk;

    inst_mem_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_data (ld_data),
        .ld_last (ld_last),
        .start   (start),
        .i_dir   (i_dir),
        .rd_en   (rd_en),
        .o_dir   (o_dir),
        .o_valid (o_valid),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_err   (o_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < DEPTH; i++) model[i] = 16'hFFFF;
    endtask

    // Counts cycles until ld_ready; also counts cycles that were not busy or had o_valid.
    task automatic wait_ready(output int n, output int odd);
        n = 0;
        odd = 0;
        while (!ld_ready && n < 2000) begin
            tick;
            n++;
            if (!o_busy || o_valid) odd++;
        end
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
        model_clear();
    endtask

    task automatic load(input logic [15:0] w[$], input bit use_last,
                        input int gap, output int acc);
        int i;
        int cyc;
        acc = 0;
        i = 0;
        cyc = 0;
        while (i < w.size() && acc < DEPTH && cyc < 5000) begin
            bit v;
            bit rdy;
            v = ($urandom_range(99) >= gap);
            rdy = ld_ready;
            ld_valid = v;
            ld_data = w[i];
            ld_last = use_last && (i == w.size() - 1);
            tick;
            cyc++;
            if (v && rdy) begin
                model[acc] = w[i];
                acc++;
                i++;
            end
        end
        ld_valid = 1'b0;
        ld_last = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        rd_en = 1'b1;
        i_dir = a;
        tick;
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        int n, odd, acc;
        logic [15:0] w0;
        logic [15:0] q[$];
        rst_n = 1'b0;
        rd_en = 1'b1;
        repeat (3) tick;
        total++; if (o_dir !== 16'hFFFF) begin bad++; $display("FAIL rst_dir got=%h exp=ffff", o_dir); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", o_done); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", o_err); end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ld_ready); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", o_busy); end
        rst_n = 1'b1;
        model_clear();
        wait_ready(n, odd);
        rd_en = 1'b0;
        total++; if (n != DEPTH) begin bad++; $display("FAIL rst_clear_len got=%0d exp=%0d", n, DEPTH); end
        total++; if (odd != 0) begin bad++; $display("FAIL rst_clear_busy got=%0d exp=0", odd); end
        w0 = 16'($urandom);
        q.push_back(w0);
        load(q, 1'b1, 0, acc);
        total++; if (acc != 1) begin bad++; $display("FAIL one_acc got=%0d exp=1", acc); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL one_busy got=%b exp=0", o_busy); end
        fetch(32'd5);
        total++; if (o_dir !== 16'hFFFF || o_valid !== 1'b1) begin bad++; $display("FAIL one_rd5 got=%h/%b exp=ffff/1", o_dir, o_valid); end
        fetch(32'd0);
        total++; if (o_dir !== model[0]) begin bad++; $display("FAIL one_rd0 got=%h exp=%h", o_dir, model[0]); end
    endtask

    task automatic test_program;
        int n, odd, acc;
        logic [15:0] q[$];
        do_start();
        wait_ready(n, odd);
        total++; if (n != DEPTH) begin bad++; $display("FAIL prog_clear_len got=%0d exp=%0d", n, DEPTH); end
        q = '{16'hb300, 16'hb200, 16'hb100, 16'h8b11, 16'he006};
        load(q, 1'b1, 30, acc);
        total++; if (acc != 5) begin bad++; $display("FAIL prog_acc got=%0d exp=5", acc); end
        total++; if (ld_ready !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL prog_run got=%b/%b exp=0/0", ld_ready, o_busy); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL prog_pre got=%b exp=0", o_valid); end
        fetch(32'd3);
        total++; if (o_dir !== 16'h8b11 || o_valid !== 1'b1) begin bad++; $display("FAIL prog_rd3 got=%h/%b exp=8b11/1", o_dir, o_valid); end
        tick;
        total++; if (o_dir !== 16'h8b11 || o_valid !== 1'b0) begin bad++; $display("FAIL prog_hold got=%h/%b exp=8b11/0", o_dir, o_valid); end
        fetch(32'd4);
        total++; if (o_dir !== 16'he006) begin bad++; $display("FAIL prog_rd4 got=%h exp=e006", o_dir); end
        fetch(32'd5);
        total++; if (o_dir !== 16'hFFFF) begin bad++; $display("FAIL prog_rd5 got=%h exp=ffff", o_dir); end
        total++; if (o_err !== 1'b0 || o_done !== 1'b0) begin bad++; $display("FAIL prog_flags got=%b/%b exp=0/0", o_err, o_done); end
    endtask

    task automatic test_oor;
        fetch(32'h0000_0100);
        total++; if (o_dir !== 16'hFFFF || o_valid !== 1'b1) begin bad++; $display("FAIL oor_dir got=%h/%b exp=ffff/1", o_dir, o_valid); end
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL oor_err got=%b exp=1", o_err); end
        tick;
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL oor_sticky got=%b exp=1", o_err); end
        fetch(32'h0001_0003);
        total++; if (o_dir !== 16'hFFFF) begin bad++; $display("FAIL oor_hi got=%h exp=ffff", o_dir); end
        fetch(32'd2);
        total++; if (o_dir !== 16'hb100 || o_err !== 1'b1) begin bad++; $display("FAIL oor_rd2 got=%h/%b exp=b100/1", o_dir, o_err); end
    endtask

    task automatic test_halt;
        fetch(32'd255);
        total++; if (o_dir !== model[255] || o_valid !== 1'b1) begin bad++; $display("FAIL halt_rd got=%h/%b exp=%h/1", o_dir, o_valid, model[255]); end
        total++; if (o_done !== 1'b1) begin bad++; $display("FAIL halt_done got=%b exp=1", o_done); end
        fetch(32'd0);
        total++; if (o_valid !== 1'b0 || o_dir !== model[255]) begin bad++; $display("FAIL halt_ign got=%h/%b exp=%h/0", o_dir, o_valid, model[255]); end
        total++; if (o_done !== 1'b1) begin bad++; $display("FAIL halt_stay got=%b exp=1", o_done); end
    endtask

    task automatic test_back_to_back;
        int n, odd, acc, len;
        logic [15:0] q[$];
        logic [15:0] prev;
        start = 1'b1;
        ld_valid = 1'b1;
        ld_data = 16'h1234;
        tick;
        start = 1'b0;
        model_clear();
        wait_ready(n, odd);
        ld_valid = 1'b0;
        total++; if (n != DEPTH || odd != 0) begin bad++; $display("FAIL b2b_clear got=%0d/%0d exp=%0d/0", n, odd, DEPTH); end
        len = $urandom_range(200, 40);
        for (int i = 0; i < len; i++) q.push_back(16'($urandom));
        load(q, 1'b1, 40, acc);
        total++; if (acc != len) begin bad++; $display("FAIL b2b_acc got=%0d exp=%0d", acc, len); end
        prev = o_dir;
        for (int a = 0; a < DEPTH; a++) begin
            if ($urandom_range(3) == 0) begin
                tick;
                total++; if (o_valid !== 1'b0 || o_dir !== prev) begin bad++; $display("FAIL b2b_gap got=%h/%b exp=%h/0", o_dir, o_valid, prev); end
            end
            fetch(32'(a));
            total++; if (o_dir !== model[a] || o_valid !== 1'b1) begin bad++; $display("FAIL b2b_rd a=%0d got=%h/%b exp=%h/1", a, o_dir, o_valid, model[a]); end
            total++; if (o_done !== (a == DEPTH - 1)) begin bad++; $display("FAIL b2b_done a=%0d got=%b", a, o_done); end
            prev = model[a];
        end
    endtask

    task automatic test_full_load;
        int n, odd, acc, hi;
        logic [15:0] q[$];
        do_start();
        wait_ready(n, odd);
        total++; if (n != DEPTH) begin bad++; $display("FAIL full_clear got=%0d exp=%0d", n, DEPTH); end
        for (int i = 0; i < DEPTH + 10; i++) q.push_back(16'($urandom));
        load(q, 1'b0, 10, acc);
        total++; if (acc != DEPTH) begin bad++; $display("FAIL full_acc got=%0d exp=%0d", acc, DEPTH); end
        hi = 0;
        ld_valid = 1'b1;
        repeat (5) begin
            if (ld_ready !== 1'b0 || o_busy !== 1'b0) hi++;
            tick;
        end
        ld_valid = 1'b0;
        total++; if (hi != 0) begin bad++; $display("FAIL full_noready got=%0d exp=0", hi); end
        fetch(32'd128);
        total++; if (o_dir !== model[128]) begin bad++; $display("FAIL full_rd128 got=%h exp=%h", o_dir, model[128]); end
        fetch(32'd255);
        total++; if (o_dir !== model[255] || o_done !== 1'b1) begin bad++; $display("FAIL full_rd255 got=%h/%b exp=%h/1", o_dir, o_done, model[255]); end
    endtask

    task automatic test_start_abort;
        int n, odd, acc;
        logic [15:0] q[$];
        do_start();
        wait_ready(n, odd);
        q = '{16'h0a0a};
        load(q, 1'b1, 0, acc);
        fetch(32'h0000_0200);
        fetch(32'd255);
        total++; if (o_err !== 1'b1 || o_done !== 1'b1) begin bad++; $display("FAIL abort_pre got=%b/%b exp=1/1", o_err, o_done); end
        start = 1'b1;
        tick;
        start = 1'b0;
        model_clear();
        total++; if (o_err !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL abort_clr got=%b/%b/%b exp=0/0/1", o_err, o_done, o_busy); end
        wait_ready(n, odd);
        total++; if (n != DEPTH) begin bad++; $display("FAIL abort_clear got=%0d exp=%0d", n, DEPTH); end
        q = '{16'h1111, 16'h2222, 16'h3333};
        load(q, 1'b0, 0, acc);
        total++; if (acc != 3 || ld_ready !== 1'b1 || o_busy !== 1'b1) begin bad++; $display("FAIL abort_part got=%0d/%b/%b exp=3/1/1", acc, ld_ready, o_busy); end
        start = 1'b1;
        ld_valid = 1'b1;
        ld_data = 16'h4444;
        ld_last = 1'b1;
        tick;
        start = 1'b0;
        ld_valid = 1'b0;
        ld_last = 1'b0;
        model_clear();
        total++; if (ld_ready !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL abort_start got=%b/%b exp=0/1", ld_ready, o_busy); end
        repeat (10) tick;
        rst_n = 1'b0;
        tick;
        total++; if (o_dir !== 16'hFFFF || o_valid !== 1'b0 || ld_ready !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL abort_rst got=%h/%b/%b/%b exp=ffff/0/0/1", o_dir, o_valid, ld_ready, o_busy); end
        rst_n = 1'b1;
        wait_ready(n, odd);
        total++; if (n != DEPTH || odd != 0) begin bad++; $display("FAIL abort_reclear got=%0d/%0d exp=%0d/0", n, odd, DEPTH); end
        q = '{16'h5a5a};
        load(q, 1'b1, 0, acc);
        for (int a = 0; a < 5; a++) begin
            fetch(32'(a));
            total++; if (o_dir !== model[a]) begin bad++; $display("FAIL abort_rd a=%0d got=%h exp=%h", a, o_dir, model[a]); end
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_oor();
        test_halt();
        test_back_to_back();
        test_full_load();
        test_start_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
